// File: rtl/sha256_pad_sequencer_if.sv
// Message-in / block-out / digest handshake bundle for the SHA-256 pad sequencer.
// The master side is the message source and compression core; the slave side is the sequencer.
interface sha256_pad_sequencer_if;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic         msg_last;
  logic [2:0]   msg_nbytes;
  logic         msg_abort;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_valid;
  logic         blk_ready;
  logic         core_done;
  logic [255:0] core_hash;
  logic [255:0] hash_out;
  logic         hash_valid;

  modport master (
    output msg_data, msg_valid, msg_last, msg_nbytes, msg_abort, blk_ready,
           core_done, core_hash,
    input  msg_ready, blk_data, blk_first, blk_valid, hash_out, hash_valid
  );

  modport slave (
    input  msg_data, msg_valid, msg_last, msg_nbytes, msg_abort, blk_ready,
           core_done, core_hash,
    output msg_ready, blk_data, blk_first, blk_valid, hash_out, hash_valid
  );
endinterface

// File: rtl/sha256_pad_sequencer.sv
// Packs a big-endian word stream into padded 512-bit SHA-256 blocks and sequences the core.
// Optional abort support is compiled in with `define SHA256_SEQ_ABORT_EN.
module sha256_pad_sequencer (
  input  logic                          clk,
  input  logic                          rst,
  sha256_pad_sequencer_if.slave         bus
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    buf_q [16];
  logic [31:0]    buf_d [16];
  logic [4:0]     idx_q, idx_d;
  logic [63:0]    len_q, len_d;
  logic           first_q, first_d;
  logic           final_q, final_d;
  logic           trail_q, trail_d;
  logic           mark80_q, mark80_d;
  logic           abort_q, abort_d;
  logic [255:0]   hash_q, hash_d;

  logic           accept;
  logic           abort_req;
  logic [2:0]     nb;
  logic [63:0]    len_base;
  logic [511:0]   blk_flat;

  function automatic logic [2:0] sat_nbytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

  // Keep the valid leading bytes, drop the rest and place the 0x80 marker right after them.
  function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    return 32'h8000_0000;
      3'd1:    return {d[31:24], 24'h80_0000};
      3'd2:    return {d[31:16], 16'h8000};
      3'd3:    return {d[31:8], 8'h80};
      default: return d;
    endcase
  endfunction

`ifdef SHA256_SEQ_ABORT_EN
  assign abort_req = bus.msg_abort;
`else
  logic unused_abort;
  assign unused_abort = bus.msg_abort;
  assign abort_req    = 1'b0;
`endif

  assign bus.msg_ready  = !rst && (state_q == IDLE || state_q == FILL);
  assign accept         = bus.msg_valid && bus.msg_ready;
  assign nb             = sat_nbytes(bus.msg_nbytes);
  assign len_base       = (state_q == IDLE) ? 64'd0 : len_q;

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign blk_flat[511-32*g -: 32] = buf_q[g];
  end

  assign bus.blk_data   = blk_flat;
  assign bus.blk_valid  = (state_q == ISSUE);
  assign bus.blk_first  = first_q;
  assign bus.hash_out   = hash_q;
  assign bus.hash_valid = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    len_d    = len_q;
    first_d  = first_q;
    final_d  = final_q;
    trail_d  = trail_q;
    mark80_d = mark80_q;
    abort_d  = abort_q;
    hash_d   = hash_q;

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (state_q == IDLE) begin
            first_d  = 1'b1;
            final_d  = 1'b0;
            trail_d  = 1'b0;
            mark80_d = 1'b0;
          end
          if (bus.msg_last) begin
            buf_d[idx_q[3:0]] = pad_last(bus.msg_data, nb);
            len_d = len_base + {58'd0, nb, 3'd0};
            if (nb != 3'd4) begin
              idx_d   = idx_q + 5'd1;
              state_d = PAD;
            end else if (idx_q != 5'd15) begin
              buf_d[idx_q[3:0] + 4'd1] = 32'h8000_0000;
              idx_d   = idx_q + 5'd2;
              state_d = PAD;
            end else begin
              // Full last word fills the block: the marker opens a trailer block.
              idx_d    = 5'd0;
              trail_d  = 1'b1;
              mark80_d = 1'b1;
              state_d  = ISSUE;
            end
          end else begin
            buf_d[idx_q[3:0]] = bus.msg_data;
            len_d = len_base + 64'd32;
            if (idx_q == 5'd15) begin
              idx_d   = 5'd0;
              state_d = ISSUE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = FILL;
            end
          end
        end
      end

      PAD: begin
        if (idx_q < 5'd14) begin
          buf_d[idx_q[3:0]] = 32'd0;
          idx_d = idx_q + 5'd1;
        end else if (idx_q == 5'd14) begin
          buf_d[14] = len_q[63:32];
          buf_d[15] = len_q[31:0];
          final_d   = 1'b1;
          idx_d     = 5'd0;
          state_d   = ISSUE;
        end else begin
          // No room for the length: close this block and owe a length-only block.
          if (idx_q == 5'd15) buf_d[15] = 32'd0;
          trail_d  = 1'b1;
          mark80_d = 1'b0;
          idx_d    = 5'd0;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.blk_ready) begin
          first_d = 1'b0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.core_done) begin
          if (abort_q || abort_req) begin
            abort_d = 1'b0;
            final_d = 1'b0;
            trail_d = 1'b0;
            mark80_d = 1'b0;
            idx_d   = 5'd0;
            len_d   = 64'd0;
            state_d = IDLE;
          end else if (final_q) begin
            hash_d  = bus.core_hash;
            final_d = 1'b0;
            state_d = DONE;
          end else if (trail_q) begin
            trail_d  = 1'b0;
            mark80_d = 1'b0;
            if (mark80_q) begin
              buf_d[0] = 32'h8000_0000;
              idx_d    = 5'd1;
            end else begin
              idx_d    = 5'd0;
            end
            state_d = PAD;
          end else begin
            idx_d   = 5'd0;
            state_d = FILL;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_req) begin
      if (state_q == FILL || state_q == PAD) begin
        for (int i = 0; i < 16; i++) buf_d[i] = 32'd0;
        len_d    = 64'd0;
        idx_d    = 5'd0;
        first_d  = 1'b0;
        final_d  = 1'b0;
        trail_d  = 1'b0;
        mark80_d = 1'b0;
        state_d  = IDLE;
      end else if (state_q == ISSUE || (state_q == WAIT && !bus.core_done)) begin
        abort_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < 16; i++) buf_q[i] <= 32'd0;
      idx_q    <= 5'd0;
      len_q    <= 64'd0;
      first_q  <= 1'b0;
      final_q  <= 1'b0;
      trail_q  <= 1'b0;
      mark80_q <= 1'b0;
      abort_q  <= 1'b0;
      hash_q   <= 256'd0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      first_q  <= first_d;
      final_q  <= final_d;
      trail_q  <= trail_d;
      mark80_q <= mark80_d;
      abort_q  <= abort_d;
      hash_q   <= hash_d;
    end
  end

endmodule

// File: tb/tb_sha256_pad_sequencer.sv
// Directed bench for sha256_pad_sequencer with a behavioural SHA-256 compression core.
module tb_sha256_pad_sequencer;

  logic clk;
  logic rst;
  sha256_pad_sequencer_if bus();

  sha256_pad_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  int n_vec = 0;
  int n_err = 0;
  int hv_cnt = 0;
  logic [511:0] blk_log [$];
  bit           first_log [$];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [31:0] dw(input int i);
    return 32'h30313233 + 32'(i) * 32'h01010101;
  endfunction

  function automatic logic [511:0] data_blk(input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[511-32*i -: 32] = dw(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compression core model: accepts a block, answers with a one-cycle core_done a few cycles later.
  initial begin
    logic [255:0] hm;
    hm = IV;
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    forever begin
      @(negedge clk); #2;
      if (bus.blk_valid && bus.blk_ready && !rst) begin
        blk_log.push_back(bus.blk_data);
        first_log.push_back(bus.blk_first);
        hm = sha_compress(bus.blk_first ? IV : hm, bus.blk_data);
        repeat (3) @(negedge clk);
        #2;
        bus.core_hash = hm;
        bus.core_done = 1'b1;
        @(negedge clk); #2;
        bus.core_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.hash_valid === 1'b1) hv_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    bus.msg_data = d; bus.msg_last = last; bus.msg_nbytes = nb; bus.msg_valid = 1'b1;
    t = 0;
    while (!bus.msg_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("send_timeout", 512'd0, 512'd1);
    else begin @(posedge clk); @(negedge clk); end
    bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
  endtask

  task automatic send_msg(input int nfull, input logic [31:0] lastw, input logic [2:0] nb);
    for (int i = 0; i < nfull; i++) send_word(dw(i), 1'b0, 3'd0);
    send_word(lastw, 1'b1, nb);
  endtask

  task automatic wait_hash(input string tag);
    int start, t;
    start = hv_cnt; t = 0;
    while (hv_cnt == start && t < 400) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({tag, "_hv"}, 512'(hv_cnt - start), 512'd1);
  endtask

  task automatic check_msg(input string tag, input int nb0, input int nblk,
                           input logic [511:0] e1, input logic [511:0] e2, input logic [255:0] dig);
    chk({tag, "_nblk"}, 512'(blk_log.size() - nb0), 512'(nblk));
    if (blk_log.size() >= nb0 + nblk) begin
      chk({tag, "_blk1"}, blk_log[nb0], e1);
      chk({tag, "_first1"}, 512'(first_log[nb0]), 512'd1);
      if (nblk == 2) begin
        chk({tag, "_blk2"}, blk_log[nb0+1], e2);
        chk({tag, "_first2"}, 512'(first_log[nb0+1]), 512'd0);
      end
    end
    chk({tag, "_hash"}, 512'(bus.hash_out), 512'(dig));
  endtask

  initial begin
    logic [511:0] e1, e2, snap;
    int nb0, t, hv0;
    bit stable;

    rst = 1'b1;
    bus.msg_data = '0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
    bus.msg_nbytes = '0; bus.msg_abort = 1'b0; bus.blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", 512'(bus.msg_ready), 512'd0);
    chk("rst_blk_valid", 512'(bus.blk_valid), 512'd0);
    chk("rst_blk_first", 512'(bus.blk_first), 512'd0);
    chk("rst_hash_valid", 512'(bus.hash_valid), 512'd0);
    chk("rst_hash_out", 512'(bus.hash_out), 512'd0);
    chk("rst_blk_data", bus.blk_data, 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 512'(bus.msg_ready), 512'd1);

    nb0 = blk_log.size();
    send_word(32'h1234_5678, 1'b1, 3'd0);
    wait_hash("empty");
    check_msg("empty", nb0, 1, {32'h8000_0000, 480'h0}, '0, DIG_EMPTY);

    nb0 = blk_log.size();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_hash("abc");
    check_msg("abc", nb0, 1, {32'h6162_6380, 448'h0, 32'h18}, '0, DIG_ABC);
    repeat (6) @(negedge clk);
    chk("abc_hold", 512'(bus.hash_out), 512'(DIG_ABC));

    nb0 = blk_log.size();
    e1 = {32'h1122_3344, 32'h8000_0000, 416'h0, 32'h20};
    send_word(32'h1122_3344, 1'b1, 3'd7);
    wait_hash("nb7");
    check_msg("nb7", nb0, 1, e1, '0, sha_compress(IV, e1));

    nb0 = blk_log.size();
    e1 = {32'hAABB_8000, 448'h0, 32'h10};
    send_word(32'hAABB_CCDD, 1'b1, 3'd2);
    wait_hash("nb2");
    check_msg("nb2", nb0, 1, e1, '0, sha_compress(IV, e1));

    nb0 = blk_log.size();
    e1 = data_blk(14) | {448'h0, 32'h8000_0000, 32'h0};
    e2 = {480'h0, 32'h1C0};
    send_msg(13, dw(13), 3'd4);
    wait_hash("b56");
    check_msg("b56", nb0, 2, e1, e2, sha_compress(sha_compress(IV, e1), e2));

    nb0 = blk_log.size();
    e1 = data_blk(15) | {480'h0, 32'h8000_0000};
    e2 = {480'h0, 32'h1E0};
    send_msg(15, 32'hDEAD_BEEF, 3'd0);
    wait_hash("b60");
    check_msg("b60", nb0, 2, e1, e2, sha_compress(sha_compress(IV, e1), e2));

    nb0 = blk_log.size();
    e1 = data_blk(16);
    e2 = {32'h8000_0000, 448'h0, 32'h200};
    bus.blk_ready = 1'b0;
    send_msg(15, dw(15), 3'd4);
    t = 0;
    while (!bus.blk_valid && t < 50) begin @(negedge clk); t++; end
    snap = bus.blk_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== snap) stable = 1'b0;
    end
    chk("stall_stable", 512'(stable), 512'd1);
    chk("stall_ready_low", 512'(bus.msg_ready), 512'd0);
    chk("stall_data", snap, e1);
    bus.blk_ready = 1'b1;
    wait_hash("b64");
    check_msg("b64", nb0, 2, e1, e2, sha_compress(sha_compress(IV, e1), e2));

`ifdef SHA256_SEQ_ABORT_EN
    nb0 = blk_log.size();
    for (int i = 0; i < 5; i++) send_word(dw(i), 1'b0, 3'd0);
    bus.msg_abort = 1'b1;
    @(negedge clk);
    bus.msg_abort = 1'b0;
    chk("abort_idle_ready", 512'(bus.msg_ready), 512'd1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_hash("abort_abc");
    check_msg("abort_abc", nb0, 1, {32'h6162_6380, 448'h0, 32'h18}, '0, DIG_ABC);
`else
    nb0 = blk_log.size();
    bus.msg_abort = 1'b1;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_hash("noabort_abc");
    bus.msg_abort = 1'b0;
    check_msg("noabort_abc", nb0, 1, {32'h6162_6380, 448'h0, 32'h18}, '0, DIG_ABC);
`endif

    nb0 = blk_log.size();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    t = 0;
    while (blk_log.size() == nb0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    rst = 1'b1;
    hv0 = hv_cnt;
    @(negedge clk);
    chk("wait_rst_ready", 512'(bus.msg_ready), 512'd0);
    chk("wait_rst_valid", 512'(bus.blk_valid), 512'd0);
    chk("wait_rst_hash", 512'(bus.hash_out), 512'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("wait_rst_no_hv", 512'(hv_cnt - hv0), 512'd0);
    chk("wait_rst_idle", 512'(bus.msg_ready), 512'd1);

    nb0 = blk_log.size();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_hash("re_abc");
    check_msg("re_abc", nb0, 1, {32'h6162_6380, 448'h0, 32'h18}, '0, DIG_ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
